// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Control sequencer for a multi-cycle RV32I datapath. Each instruction walks
// FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB). The instruction and data
// memories may stall through the imem_ready / dmem_ready handshakes. A bounded
// wait counter turns a stalled memory into a sticky trap.
//
// Parameters
//   SUPPORT_SHIFT_SLT : 1 enables sll/srl/sra/slt/sltu (R and I forms)
//   FULL_BRANCH       : 1 enables blt/bge/bltu/bgeu (beq/bne always legal)
//   MEM_TIMEOUT       : wait cycles tolerated on imem/dmem, 0 = no timeout
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   instr             : instruction register contents (stable DECODE..retire)
//   imem_ready        : instruction word valid this cycle
//   dmem_ready        : data access completes this cycle
//   branch_taken      : comparator result for branch_cond
//   imem_req/dmem_req : memory requests
//   ir_write          : load the instruction register
//   pc_write, pc_src  : PC update enable / source (0 PC+4, 1 PC+imm, 2 alu&~1)
//   alu_ctrl          : 0 add 1 sub 2 and 3 or 4 xor 5 sll 6 srl 7 sra 8 slt 9 sltu
//   alu_src_a/_b      : ALU operand selects (a: 0 rs1 1 PC 2 zero; b: 0 rs2 1 imm)
//   mem_read/write    : data access type, meaningful only with dmem_req
//   reg_write, wb_sel : register write enable / source (0 alu 1 mem 2 PC+4)
//   is_branch         : branch evaluation cycle, branch_cond = funct3
//   retire            : one-cycle pulse when an instruction completes
//   trap              : sticky fault flag
//   state_o           : FETCH=0 DECODE=1 EXECUTE=2 MEM=3 WB=4 TRAP=5
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter bit SUPPORT_SHIFT_SLT = 1'b1,
    parameter bit FULL_BRANCH       = 1'b1,
    parameter int MEM_TIMEOUT       = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        branch_taken,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [3:0]  alu_ctrl,
    output logic [1:0]  alu_src_a,
    output logic        alu_src_b,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        is_branch,
    output logic [2:0]  branch_cond,
    output logic        retire,
    output logic        trap,
    output logic [2:0]  state_o
);

    // A zero timeout still needs a one-bit counter to keep the logic legal.
    localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_ALU    = 3'd0,   // R/I ALU ops plus lui/auipc
        C_LOAD   = 3'd1,
        C_STORE  = 3'd2,
        C_BRANCH = 3'd3,
        C_JAL    = 3'd4,
        C_JALR   = 3'd5
    } cls_t;

    state_t           state_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    cls_t             cls_reg;
    logic [3:0]       alu_reg;
    logic [1:0]       src_a_reg;
    logic             src_b_reg;
    logic [1:0]       wb_sel_reg;
    logic [2:0]       br_cond_reg;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Register and immediate fields are the datapath's business.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    // alt selects sub (funct3 000) or sra (funct3 101).
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // ---------------- combinational instruction decode ----------------
    logic       dec_illegal;
    cls_t       dec_cls;
    logic [3:0] dec_alu;
    logic [1:0] dec_src_a;
    logic       dec_src_b;
    logic [1:0] dec_wb_sel;
    logic       shift_slt_op;

    assign shift_slt_op = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                          (funct3 == 3'b011) || (funct3 == 3'b101);

    always_comb begin
        dec_illegal = 1'b0;
        dec_cls     = C_ALU;
        dec_alu     = ALU_ADD;
        dec_src_a   = 2'd0;
        dec_src_b   = 1'b0;
        dec_wb_sel  = 2'd0;
        case (opcode)
            OP_R: begin
                if (funct7 != 7'b0000000 && funct7 != 7'b0100000)
                    dec_illegal = 1'b1;
                if (funct7 == 7'b0100000 && funct3 != 3'b000 && funct3 != 3'b101)
                    dec_illegal = 1'b1;
                if (!SUPPORT_SHIFT_SLT && shift_slt_op)
                    dec_illegal = 1'b1;
                dec_alu = alu_from_funct3(funct3, funct7[5]);
            end
            OP_I: begin
                if (!SUPPORT_SHIFT_SLT && shift_slt_op)
                    dec_illegal = 1'b1;
                // Bit 30 is part of the immediate except for srai.
                dec_alu   = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
                dec_src_b = 1'b1;
            end
            OP_LOAD: begin
                dec_cls     = C_LOAD;
                dec_src_b   = 1'b1;
                dec_wb_sel  = 2'd1;
                dec_illegal = (funct3 != 3'b010);
            end
            OP_STORE: begin
                dec_cls     = C_STORE;
                dec_src_b   = 1'b1;
                dec_illegal = (funct3 != 3'b010);
            end
            OP_BRANCH: begin
                dec_cls     = C_BRANCH;
                dec_alu     = ALU_SUB;
                dec_illegal = (funct3 == 3'b010) || (funct3 == 3'b011) ||
                              (!FULL_BRANCH && funct3[2]);
            end
            OP_JAL: begin
                dec_cls    = C_JAL;
                dec_src_a  = 2'd1;
                dec_src_b  = 1'b1;
                dec_wb_sel = 2'd2;
            end
            OP_JALR: begin
                dec_cls     = C_JALR;
                dec_src_b   = 1'b1;
                dec_wb_sel  = 2'd2;
                dec_illegal = (funct3 != 3'b000);
            end
            OP_LUI: begin
                dec_src_a = 2'd2;
                dec_src_b = 1'b1;
            end
            OP_AUIPC: begin
                dec_src_a = 2'd1;
                dec_src_b = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // The counter has reached its limit; only meaningful with a nonzero timeout.
    logic wait_expired;
    assign wait_expired = (MEM_TIMEOUT != 0) && (wait_cnt_reg == CNT_LIMIT);

    // ---------------- state sequencer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
            cls_reg      <= C_ALU;
            alu_reg      <= ALU_ADD;
            src_a_reg    <= 2'd0;
            src_b_reg    <= 1'b0;
            wb_sel_reg   <= 2'd0;
            br_cond_reg  <= 3'd0;
        end else begin
            // Any state change clears the counter; waiting states override below.
            wait_cnt_reg <= '0;
            case (state_reg)
                S_FETCH: begin
                    // A ready on the limit cycle wins over the timeout.
                    if (imem_ready)
                        state_reg <= S_DECODE;
                    else if (wait_expired)
                        state_reg <= S_TRAP;
                    else if (wait_cnt_reg != CNT_MAX)
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    else
                        wait_cnt_reg <= wait_cnt_reg;
                end
                S_DECODE: begin
                    cls_reg     <= dec_cls;
                    alu_reg     <= dec_alu;
                    src_a_reg   <= dec_src_a;
                    src_b_reg   <= dec_src_b;
                    wb_sel_reg  <= dec_wb_sel;
                    br_cond_reg <= funct3;
                    state_reg   <= dec_illegal ? S_TRAP : S_EXECUTE;
                end
                S_EXECUTE: begin
                    case (cls_reg)
                        C_BRANCH:         state_reg <= S_FETCH;
                        C_LOAD, C_STORE:  state_reg <= S_MEM;
                        default:          state_reg <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready)
                        state_reg <= (cls_reg == C_LOAD) ? S_WB : S_FETCH;
                    else if (wait_expired)
                        state_reg <= S_TRAP;
                    else if (wait_cnt_reg != CNT_MAX)
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    else
                        wait_cnt_reg <= wait_cnt_reg;
                end
                S_WB:    state_reg <= S_FETCH;
                S_TRAP:  state_reg <= S_TRAP;
                default: state_reg <= S_TRAP;
            endcase
        end
    end

    // ---------------- output decode ----------------
    // Everything is a function of the registered state and decode registers,
    // except the branch pc_src and the ready-qualified handshake strobes.
    // Outputs are forced low while reset is held.
    always_comb begin
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'd0;
        alu_ctrl    = ALU_ADD;
        alu_src_a   = 2'd0;
        alu_src_b   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        wb_sel      = 2'd0;
        is_branch   = 1'b0;
        branch_cond = 3'd0;
        retire      = 1'b0;
        trap        = 1'b0;
        if (rst_n) begin
            case (state_reg)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ready;
                end
                S_EXECUTE: begin
                    alu_ctrl  = alu_reg;
                    alu_src_a = src_a_reg;
                    alu_src_b = src_b_reg;
                    if (cls_reg == C_BRANCH) begin
                        is_branch   = 1'b1;
                        branch_cond = br_cond_reg;
                        pc_write    = 1'b1;
                        retire      = 1'b1;
                        pc_src      = branch_taken ? 2'd1 : 2'd0;
                    end
                end
                S_MEM: begin
                    dmem_req  = 1'b1;
                    mem_read  = (cls_reg == C_LOAD);
                    mem_write = (cls_reg == C_STORE);
                    if (cls_reg == C_STORE && dmem_ready) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                    wb_sel    = wb_sel_reg;
                    if (cls_reg == C_JAL)
                        pc_src = 2'd1;
                    else if (cls_reg == C_JALR)
                        pc_src = 2'd2;
                    else
                        pc_src = 2'd0;
                end
                S_TRAP:  trap = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_o = state_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Two control units run side by side on the same stimulus: instance 0 with
// the full instruction set and a 15-cycle timeout, instance 1 with shifts/slt
// and the extended branches disabled and a 4-cycle timeout. For each
// instruction the bench derives the expected cycle-by-cycle phase sequence
// from wait counts and an instruction classification, and compares all
// outputs of the selected instance as one packed word every cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

    localparam int OW = 27;
    localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4, PH_T = 5, PH_RST = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        branch_taken = 1'b0;

    wire [OW-1:0] o [2];

    int checks = 0;
    int errors = 0;

    // alu code indexed by funct3; the alternate forms (sub, sra) are code+1.
    int alu_of_f3 [8] = '{0, 5, 8, 9, 4, 6, 3, 2};

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        multicycle_control_unit #(
            .SUPPORT_SHIFT_SLT(gi == 0),
            .FULL_BRANCH      (gi == 0),
            .MEM_TIMEOUT      ((gi == 0) ? 15 : 4)
        ) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .instr       (instr),
            .imem_ready  (imem_ready),
            .dmem_ready  (dmem_ready),
            .branch_taken(branch_taken),
            .imem_req    (o[gi][26]),
            .dmem_req    (o[gi][25]),
            .ir_write    (o[gi][24]),
            .pc_write    (o[gi][23]),
            .pc_src      (o[gi][22:21]),
            .alu_ctrl    (o[gi][20:17]),
            .alu_src_a   (o[gi][16:15]),
            .alu_src_b   (o[gi][14]),
            .mem_read    (o[gi][13]),
            .mem_write   (o[gi][12]),
            .reg_write   (o[gi][11]),
            .wb_sel      (o[gi][10:9]),
            .is_branch   (o[gi][8]),
            .branch_cond (o[gi][7:5]),
            .retire      (o[gi][4]),
            .trap        (o[gi][3]),
            .state_o     (o[gi][2:0])
        );
    end

    // Instruction classification from the RV32I rules.
    // kind: 0 alu/lui/auipc, 1 load, 2 store, 3 branch, 4 jal, 5 jalr
    task automatic ref_decode(input logic [31:0] ins, input bit sh, input bit fb,
                              output bit legal, output int kind, output int alu,
                              output int sa, output int sb);
        int op, f3, f7;
        bit shop;
        op = int'(ins[6:0]);
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        shop = (f3 == 1) || (f3 == 2) || (f3 == 3) || (f3 == 5);
        legal = 1; kind = 0; alu = 0; sa = 0; sb = 0;
        if (op == 'h33) begin
            legal = (f7 == 0 || f7 == 32) && (f7 == 0 || f3 == 0 || f3 == 5) && (sh || !shop);
            alu = alu_of_f3[f3] + ((f7 == 32) ? 1 : 0);
        end else if (op == 'h13) begin
            legal = sh || !shop;
            alu = alu_of_f3[f3] + ((f3 == 5 && ins[30]) ? 1 : 0);
            sb = 1;
        end else if (op == 'h03 || op == 'h23) begin
            kind = (op == 'h03) ? 1 : 2;
            legal = (f3 == 2);
            sb = 1;
        end else if (op == 'h63) begin
            kind = 3; alu = 1;
            legal = (f3 != 2) && (f3 != 3) && (fb || f3 < 2);
        end else if (op == 'h6F) begin
            kind = 4; sa = 1; sb = 1;
        end else if (op == 'h67) begin
            kind = 5; sb = 1;
            legal = (f3 == 0);
        end else if (op == 'h37) begin
            sa = 2; sb = 1;
        end else if (op == 'h17) begin
            sa = 1; sb = 1;
        end else begin
            legal = 0;
        end
    endtask

    // Expected output word for one cycle of a given phase.
    function automatic logic [OW-1:0] expv(input int ph, input int kind, input int alu,
                                           input int sa, input int sb, input logic [2:0] f3,
                                           input bit ir, input bit dr, input bit bt);
        logic imr, dmr, irw, pcw, asb, mr, mw, rw, isb, ret, trp;
        logic [1:0] pcs, asa, wbs;
        logic [3:0] ac;
        logic [2:0] bc, st;
        {imr, dmr, irw, pcw, asb, mr, mw, rw, isb, ret, trp} = '0;
        pcs = 2'd0; asa = 2'd0; wbs = 2'd0; ac = 4'd0; bc = 3'd0; st = 3'd0;
        case (ph)
            PH_F: begin st = 3'd0; imr = 1; irw = ir; end
            PH_D: st = 3'd1;
            PH_E: begin
                st = 3'd2; ac = 4'(alu); asa = 2'(sa); asb = 1'(sb);
                if (kind == 3) begin
                    isb = 1; bc = f3; pcw = 1; ret = 1; pcs = bt ? 2'd1 : 2'd0;
                end
            end
            PH_M: begin
                st = 3'd3; dmr = 1; mr = (kind == 1); mw = (kind == 2);
                if (kind == 2 && dr) begin pcw = 1; ret = 1; end
            end
            PH_W: begin
                st = 3'd4; rw = 1; pcw = 1; ret = 1;
                wbs = (kind == 1) ? 2'd1 : ((kind >= 4) ? 2'd2 : 2'd0);
                pcs = (kind == 4) ? 2'd1 : ((kind == 5) ? 2'd2 : 2'd0);
            end
            PH_T: begin st = 3'd5; trp = 1; end
            default: ;
        endcase
        return {imr, dmr, irw, pcw, pcs, ac, asa, asb, mr, mw, rw, wbs, isb, bc, ret, trp, st};
    endfunction

    task automatic noise();
        imem_ready   = 1'($urandom);
        dmem_ready   = 1'($urandom);
        branch_taken = 1'($urandom);
    endtask

    // Inputs are already driven; check at the falling edge, then advance.
    task automatic step(input int sel, input logic [OW-1:0] exp, input string tag);
        logic [OW-1:0] obs;
        @(negedge clk);
        obs = o[sel];
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d instr=%h observed=%h expected=%h", tag, sel, instr, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int sel);
        rst_n = 1'b0;
        noise();
        step(sel, expv(PH_RST, 0, 0, 0, 0, 3'd0, 0, 0, 0), "reset");
        noise();
        step(sel, expv(PH_RST, 0, 0, 0, 0, 3'd0, 0, 0, 0), "reset");
        rst_n = 1'b1;
    endtask

    task automatic trap_tail(input int sel);
        for (int k = 0; k < 3; k++) begin
            noise();
            step(sel, expv(PH_T, 0, 0, 0, 0, 3'd0, 0, 0, 0), "trap_sticky");
        end
    endtask

    // Run one instruction with wi fetch wait cycles and wd data wait cycles.
    task automatic run_instr(input int sel, input logic [31:0] ins, input int wi,
                             input int wd, input bit bt, output bit trapped);
        bit legal;
        int kind, alu, sa, sb, tmo;
        logic [2:0] f3;
        tmo = (sel == 0) ? 15 : 4;
        ref_decode(ins, sel == 0, sel == 0, legal, kind, alu, sa, sb);
        f3 = ins[14:12];
        trapped = 0;
        instr = ins;
        for (int c = 0; c <= wi; c++) begin
            noise();
            imem_ready = (c == wi);
            step(sel, expv(PH_F, kind, alu, sa, sb, f3, imem_ready, 0, 0), "fetch");
            if (!imem_ready && c == tmo) begin trapped = 1; break; end
        end
        if (trapped) begin trap_tail(sel); return; end
        noise();
        step(sel, expv(PH_D, kind, alu, sa, sb, f3, 0, 0, 0), "decode");
        if (!legal) begin trapped = 1; trap_tail(sel); return; end
        noise();
        branch_taken = bt;
        step(sel, expv(PH_E, kind, alu, sa, sb, f3, 0, 0, bt), "execute");
        if (kind == 3) return;
        if (kind == 1 || kind == 2) begin
            for (int c = 0; c <= wd; c++) begin
                noise();
                dmem_ready = (c == wd);
                step(sel, expv(PH_M, kind, alu, sa, sb, f3, 0, dmem_ready, 0), "mem");
                if (!dmem_ready && c == tmo) begin trapped = 1; break; end
            end
            if (trapped) begin trap_tail(sel); return; end
            if (kind == 2) return;
        end
        noise();
        step(sel, expv(PH_W, kind, alu, sa, sb, f3, 0, 0, 0), "writeback");
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0] op;
        ins = $urandom;
        case ($urandom_range(0, 9))
            0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h03;  3: op = 7'h23;
            4: op = 7'h63;  5: op = 7'h6F;  6: op = 7'h67;  7: op = 7'h37;
            8: op = 7'h17;  default: op = 7'($urandom);
        endcase
        ins[6:0] = op;
        case ($urandom_range(0, 3))
            0, 1: ins[31:25] = 7'h00;
            2:    ins[31:25] = 7'h20;
            default: ;
        endcase
        if ((op == 7'h03 || op == 7'h23) && $urandom_range(0, 3) != 0) ins[14:12] = 3'd2;
        if (op == 7'h67 && $urandom_range(0, 3) != 0) ins[14:12] = 3'd0;
        return ins;
    endfunction

    initial begin
        bit tr;
        int wi, wd;

        do_reset(0);
        // add / sub through the ALU path
        run_instr(0, 32'h002081B3, 0, 0, 0, tr);
        run_instr(0, 32'h402081B3, 0, 0, 0, tr);
        // lw with three data wait cycles, then sw
        run_instr(0, 32'h0040A283, 0, 3, 0, tr);
        run_instr(0, 32'h0020A423, 1, 2, 0, tr);
        // beq taken and not taken
        run_instr(0, 32'h00208463, 0, 0, 1, tr);
        run_instr(0, 32'h00208463, 0, 0, 0, tr);
        // jal, jalr, lui, auipc
        run_instr(0, 32'h008000EF, 0, 0, 0, tr);
        run_instr(0, 32'h000080E7, 0, 0, 0, tr);
        run_instr(0, 32'h123450B7, 0, 0, 0, tr);
        run_instr(0, 32'h00001097, 0, 0, 0, tr);
        // sra legal on the full instance
        run_instr(0, 32'h4020D1B3, 0, 0, 0, tr);
        // illegal word traps
        run_instr(0, 32'hFFFFFFFF, 0, 0, 0, tr);
        do_reset(0);
        // fetch timeout: ready one cycle late traps, ready on the limit does not
        run_instr(0, 32'h002081B3, 16, 0, 0, tr);
        do_reset(0);
        run_instr(0, 32'h002081B3, 15, 0, 0, tr);
        run_instr(0, 32'h0040A283, 0, 16, 0, tr);
        do_reset(0);
        run_instr(0, 32'h0040A283, 0, 15, 0, tr);

        // reset pulse while a load waits in MEM
        instr = 32'h0040A283;
        noise(); imem_ready = 1'b1;
        step(0, expv(PH_F, 1, 0, 0, 1, 3'd2, 1, 0, 0), "rst_mid_fetch");
        noise();
        step(0, expv(PH_D, 1, 0, 0, 1, 3'd2, 0, 0, 0), "rst_mid_decode");
        noise();
        step(0, expv(PH_E, 1, 0, 0, 1, 3'd2, 0, 0, 0), "rst_mid_exec");
        noise(); dmem_ready = 1'b0;
        step(0, expv(PH_M, 1, 0, 0, 1, 3'd2, 0, 0, 0), "rst_mid_mem");
        rst_n = 1'b0; dmem_ready = 1'b1;
        step(0, expv(PH_RST, 0, 0, 0, 0, 3'd0, 0, 0, 0), "rst_mid_zero");
        rst_n = 1'b1;
        run_instr(0, 32'h002081B3, 0, 0, 0, tr);

        // reduced instance: sra and blt trap, beq legal, short timeout
        do_reset(1);
        run_instr(1, 32'h00208463, 0, 0, 1, tr);
        run_instr(1, 32'h4020D1B3, 0, 0, 0, tr);
        do_reset(1);
        run_instr(1, 32'h0020C463, 0, 0, 0, tr);
        do_reset(1);
        run_instr(1, 32'h002081B3, 4, 0, 0, tr);
        run_instr(1, 32'h002081B3, 5, 0, 0, tr);
        do_reset(1);

        // randomized instruction streams
        do_reset(0);
        for (int n = 0; n < 150; n++) begin
            wi = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 17) : $urandom_range(0, 3);
            wd = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 17) : $urandom_range(0, 3);
            run_instr(0, rand_instr(), wi, wd, 1'($urandom), tr);
            if (tr) do_reset(0);
        end
        do_reset(1);
        for (int n = 0; n < 100; n++) begin
            wi = $urandom_range(0, 6);
            wd = $urandom_range(0, 6);
            run_instr(1, rand_instr(), wi, wd, 1'($urandom), tr);
            if (tr) do_reset(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
